// File: rtl/scan_refresh_engine_pkg.sv
// Shared types and helpers for the scan-chain refresh engine.
package scan_pkg;

  // One state per chain phase; wait phases are stretched by the wait counter.
  typedef enum logic [3:0] {
    IDLE,
    IN_LOAD,
    IN_SHIFT_LO,
    IN_SHIFT_HI,
    IN_LATCH_WAIT,
    IN_LATCH,
    OUT_LOAD_PRE,
    OUT_LOAD,
    OUT_LOAD_POST,
    OUT_LOAD_CLR,
    OUT_SHIFT_LO,
    OUT_SHIFT_HI,
    OUT_CAP_WAIT,
    OUT_CAP
  } scanState_e;

  // Wait-state setting a driver can use when it has no better value.
  localparam int unsigned DefaultWs = 10;

  // Width needed for a counter running 0..n-1; never less than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_refresh_engine_wait_counter.sv
// Wait-state timer: while run_i is high, done_o fires on the (cfg_i+1)-th cycle.
module scan_wait_counter #(
  parameter int WS_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic [WS_W-1:0] cfg_i,
  output logic            done_o
);

  logic [WS_W-1:0] cnt_q;
  logic [WS_W-1:0] cnt_d;

  assign done_o = run_i && (cnt_q == cfg_i);

  // Restart from zero when idle or when a wait completes, so back-to-back waits each get the full length.
  always_comb begin
    cnt_d = cnt_q + WS_W'(1);
    if (!run_i || done_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_refresh_engine.sv
// Scan-chain refresh engine: shifts a word into the selected design, latches it,
// loads all design outputs, shifts the whole chain back and captures the last word.
module scan_refresh_engine
  import scan_pkg::*;
#(
  parameter int NUM_DESIGNS = 498,
  parameter int NUM_IOS     = 8,
  parameter int SEL_W       = 9,
  parameter int WS_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               continuous,
  input  logic               start,
  input  logic [SEL_W-1:0]   active_select,
  input  logic [NUM_IOS-1:0] in_data,
  input  logic [WS_W-1:0]    ws_cfg,
  output logic [NUM_IOS-1:0] out_data,
  output logic               out_valid,
  output logic               busy,
  output logic               sel_err,
  output logic [CNT_W-1:0]   refresh_cnt,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select,
  output logic               scan_latch_en,
  input  logic               scan_data_in
);

  localparam int BIT_W = cntWidth(NUM_IOS);
  localparam int DES_W = cntWidth(NUM_DESIGNS);
  localparam logic [SEL_W:0] DesLimit = (SEL_W + 1)'(NUM_DESIGNS);

  scanState_e         state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_IOS-1:0] word_q;
  logic [WS_W-1:0]    ws_q;
  logic [BIT_W-1:0]   bit_q;
  logic [DES_W-1:0]   des_q;
  logic [NUM_IOS-1:0] capture_q;
  logic [NUM_IOS-1:0] outData_q;
  logic [CNT_W-1:0]   refreshCnt_q;
  logic               outValid_q;
  logic               selErr_q;
  logic               scanClk_q;
  logic               scanData_q;
  logic               scanSel_q;
  logic               latchEn_q;

  logic selValid;
  logic lastBit;
  logic lastInDesign;
  logic lastOutDesign;
  logic waitRun;
  logic waitDone;

  assign selValid      = ({1'b0, active_select} < DesLimit);
  assign lastBit       = (bit_q == BIT_W'(NUM_IOS - 1));
  assign lastInDesign  = (des_q == DES_W'(sel_q));
  assign lastOutDesign = (des_q == DES_W'(NUM_DESIGNS - 1));
  assign waitRun       = state_q inside {IN_LATCH_WAIT, OUT_LOAD_PRE, OUT_LOAD_POST,
                                         OUT_LOAD_CLR, OUT_CAP_WAIT};

  scan_wait_counter #(
    .WS_W(WS_W)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .run_i (waitRun),
    .cfg_i (ws_q),
    .done_o(waitDone)
  );

  assign out_data      = outData_q;
  assign out_valid     = outValid_q;
  assign busy          = (state_q != IDLE);
  assign sel_err       = selErr_q;
  assign refresh_cnt   = refreshCnt_q;
  assign scan_clk_out  = scanClk_q;
  assign scan_data_out = scanData_q;
  assign scan_select   = scanSel_q;
  assign scan_latch_en = latchEn_q;

  // Refresh sequencer; chain pins are registered decodes of the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      word_q       <= '0;
      ws_q         <= '0;
      bit_q        <= '0;
      des_q        <= '0;
      capture_q    <= '0;
      outData_q    <= '0;
      refreshCnt_q <= '0;
      outValid_q   <= 1'b0;
      selErr_q     <= 1'b0;
      scanClk_q    <= 1'b0;
      scanData_q   <= 1'b0;
      scanSel_q    <= 1'b0;
      latchEn_q    <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      selErr_q   <= 1'b0;
      scanClk_q  <= state_q inside {IN_SHIFT_HI, OUT_LOAD, OUT_SHIFT_HI};
      scanSel_q  <= state_q inside {OUT_LOAD_PRE, OUT_LOAD, OUT_LOAD_POST};
      latchEn_q  <= (state_q == IN_LATCH);
      scanData_q <= (state_q inside {IN_SHIFT_LO, IN_SHIFT_HI}) && word_q[NUM_IOS-1];

      case (state_q)
        IDLE: begin
          if (enable && (continuous || start)) begin
            if (selValid) begin
              state_q <= IN_LOAD;
            end else begin
              selErr_q <= 1'b1;
            end
          end
        end
        IN_LOAD: begin
          if (selValid) begin
            sel_q   <= active_select;
            word_q  <= in_data;
            ws_q    <= ws_cfg;
            bit_q   <= '0;
            des_q   <= '0;
            state_q <= IN_SHIFT_LO;
          end else begin
            selErr_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        IN_SHIFT_LO: state_q <= IN_SHIFT_HI;
        IN_SHIFT_HI: begin
          word_q  <= {word_q[NUM_IOS-2:0], 1'b0};
          state_q <= IN_SHIFT_LO;
          if (lastBit) begin
            bit_q <= '0;
            if (lastInDesign) begin
              des_q   <= '0;
              state_q <= IN_LATCH_WAIT;
            end else begin
              des_q <= des_q + DES_W'(1);
            end
          end else begin
            bit_q <= bit_q + BIT_W'(1);
          end
        end
        IN_LATCH_WAIT: if (waitDone) state_q <= IN_LATCH;
        IN_LATCH:      state_q <= OUT_LOAD_PRE;
        OUT_LOAD_PRE:  if (waitDone) state_q <= OUT_LOAD;
        OUT_LOAD:      state_q <= OUT_LOAD_POST;
        OUT_LOAD_POST: if (waitDone) state_q <= OUT_LOAD_CLR;
        OUT_LOAD_CLR:  if (waitDone) state_q <= OUT_SHIFT_LO;
        OUT_SHIFT_LO:  state_q <= OUT_SHIFT_HI;
        OUT_SHIFT_HI: begin
          capture_q <= {capture_q[NUM_IOS-2:0], scan_data_in};
          state_q   <= OUT_SHIFT_LO;
          if (lastBit) begin
            bit_q <= '0;
            if (lastOutDesign) begin
              des_q   <= '0;
              state_q <= OUT_CAP_WAIT;
            end else begin
              des_q <= des_q + DES_W'(1);
            end
          end else begin
            bit_q <= bit_q + BIT_W'(1);
          end
        end
        OUT_CAP_WAIT: if (waitDone) state_q <= OUT_CAP;
        OUT_CAP: begin
          outData_q    <= capture_q;
          outValid_q   <= 1'b1;
          refreshCnt_q <= refreshCnt_q + CNT_W'(1);
          state_q      <= IDLE;
          if (continuous && enable) begin
            if (selValid) begin
              state_q <= IN_LOAD;
            end else begin
              selErr_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_refresh_engine.sv
// Bench for scan_refresh_engine: table vectors, randomized refreshes and multi-cycle corner sequences.
module tb_scan_refresh_engine;

  localparam int ND    = 4;
  localparam int NI    = 8;
  localparam int SEL_W = 3;
  localparam int WS_W  = 8;
  localparam int CNT_W = 16;
  localparam int L     = ND * NI;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             continuous;
  logic             start;
  logic [SEL_W-1:0] active_select;
  logic [NI-1:0]    in_data;
  logic [WS_W-1:0]  ws_cfg;
  logic [NI-1:0]    out_data;
  logic             out_valid;
  logic             busy;
  logic             sel_err;
  logic [CNT_W-1:0] refresh_cnt;
  logic             scan_clk_out;
  logic             scan_data_out;
  logic             scan_select;
  logic             scan_latch_en;
  logic             scan_data_in;

  scan_refresh_engine #(
    .NUM_DESIGNS(ND),
    .NUM_IOS    (NI),
    .SEL_W      (SEL_W),
    .WS_W       (WS_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .continuous   (continuous),
    .start        (start),
    .active_select(active_select),
    .in_data      (in_data),
    .ws_cfg       (ws_cfg),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .busy         (busy),
    .sel_err      (sel_err),
    .refresh_cnt  (refresh_cnt),
    .scan_clk_out (scan_clk_out),
    .scan_data_out(scan_data_out),
    .scan_select  (scan_select),
    .scan_latch_en(scan_latch_en),
    .scan_data_in (scan_data_in)
  );

  always #5 clk = ~clk;

  // Observed-activity records, owned by the chain monitor below.
  int   cyc;
  int   busyRiseCnt;
  int   busyRiseCyc;
  int   busyFallCnt;
  int   scanClkCnt;
  int   latchCnt;
  int   selErrCnt;
  int   validCnt;
  int   retIdx;
  logic outPhase;
  logic busyPrev;
  logic busyAtValid;
  logic inBits[$];
  int   validCyc[$];

  // Return stream the chain model presents, one bit per output shift clock.
  logic retBits [L];

  int   checks = 0;
  int   errors = 0;
  int   modelCnt = 0;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [NI-1:0]    word;
    logic [WS_W-1:0]  ws;
    logic [NI-1:0]    ret;
    int               expLat;
    logic [NI-1:0]    expOut;
  } vec_t;

  vec_t vecs[3];

  // Chain model: records shifted-in bits and feeds the return stream after each load pulse.
  initial begin
    cyc = 0; busyRiseCnt = 0; busyRiseCyc = 0; busyFallCnt = 0; scanClkCnt = 0;
    latchCnt = 0; selErrCnt = 0; validCnt = 0; retIdx = 0;
    outPhase = 1'b0; busyPrev = 1'b0; busyAtValid = 1'b0;
    scan_data_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        outPhase = 1'b0;
        retIdx   = 0;
      end else begin
        if (busy && !busyPrev) begin
          busyRiseCnt++;
          busyRiseCyc = cyc;
        end
        if (!busy && busyPrev) busyFallCnt++;
        if (scan_clk_out) begin
          scanClkCnt++;
          if (scan_select) begin
            outPhase = 1'b1;
            retIdx   = 0;
          end else if (outPhase) begin
            retIdx++;
          end else begin
            inBits.push_back(scan_data_out);
          end
        end
        if (scan_latch_en) latchCnt++;
        if (sel_err) selErrCnt++;
        if (out_valid) begin
          validCnt++;
          validCyc.push_back(cyc);
          busyAtValid = busy;
          outPhase    = 1'b0;
        end
      end
      busyPrev     = busy;
      scan_data_in = (outPhase && retIdx < L) ? retBits[retIdx] : 1'b0;
    end
  end

  function automatic int refLatency(input int sel, input int ws);
    return 4 + 5 * (ws + 1) + 2 * ((sel + 1) + ND) * NI;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [NI-1:0] word,
                               input logic [WS_W-1:0] ws, input logic cont,
                               input logic en, input logic st);
    active_select = sel;
    in_data       = word;
    ws_cfg        = ws;
    continuous    = cont;
    enable        = en;
    start         = st;
  endtask

  // Random chain contents with the chosen word arriving last.
  task automatic loadChain(input logic [NI-1:0] tailWord);
    for (int i = 0; i < L; i++) retBits[i] = 1'($urandom);
    for (int j = 0; j < NI; j++) retBits[L - NI + j] = tailWord[NI - 1 - j];
  endtask

  task automatic waitValid(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (validCnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (validCnt < target) checkOutput({name, "_timeout"}, validCnt, target);
  endtask

  task automatic checkRefresh(input string name, input logic [SEL_W-1:0] sel, input logic [NI-1:0] word,
                              input logic [NI-1:0] expOut, input int expLat, input int bitBase,
                              input int latchBase, input int vBase);
    int   nExp;
    int   bad;
    logic expBit;
    nExp = (int'(sel) + 1) * NI;
    bad  = 0;
    checkOutput({name, "_valid_pulses"}, validCnt - vBase, 1);
    checkOutput({name, "_latency"}, (validCyc.size() > 0) ? validCyc[validCyc.size()-1] - busyRiseCyc : -1, expLat);
    checkOutput({name, "_bit_count"}, inBits.size() - bitBase, nExp);
    for (int j = 0; j < nExp; j++) begin
      expBit = (j < NI) ? word[NI - 1 - j] : 1'b0;
      if (bitBase + j >= inBits.size() || inBits[bitBase + j] !== expBit) bad++;
    end
    checkOutput({name, "_bit_values"}, bad, 0);
    checkOutput({name, "_latch_cycles"}, latchCnt - latchBase, 1);
    checkOutput({name, "_out_data"}, out_data, expOut);
    checkOutput({name, "_refresh_cnt"}, refresh_cnt, modelCnt);
    checkOutput({name, "_busy_at_valid"}, busyAtValid, 0);
    checkOutput({name, "_busy_after"}, busy, 0);
  endtask

  task automatic runRefresh(input string name, input logic [SEL_W-1:0] sel, input logic [NI-1:0] word,
                            input logic [WS_W-1:0] ws, input logic [NI-1:0] ret,
                            input int expLat, input logic [NI-1:0] expOut);
    int bitBase, latchBase, vBase;
    @(negedge clk);
    loadChain(ret);
    bitBase = inBits.size(); latchBase = latchCnt; vBase = validCnt;
    applyStimulus(sel, word, ws, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitValid(name, vBase + 1, 2000);
    modelCnt++;
    repeat (3) @(negedge clk);
    checkRefresh(name, sel, word, expOut, expLat, bitBase, latchBase, vBase);
  endtask

  initial begin
    int bitBase, latchBase, vBase, fallBase, riseBase, clkBase, errBase, bad, n;
    logic [SEL_W-1:0] rs;
    logic [NI-1:0]    rw, rr;
    logic [WS_W-1:0]  rws;

    vecs[0] = '{sel: 3'd1, word: 8'hA5, ws: 8'd2, ret: 8'h3C, expLat: 115, expOut: 8'h3C};
    vecs[1] = '{sel: 3'd0, word: 8'hFF, ws: 8'd0, ret: 8'h81, expLat: 89,  expOut: 8'h81};
    vecs[2] = '{sel: 3'd3, word: 8'h01, ws: 8'd5, ret: 8'h7E, expLat: 162, expOut: 8'h7E};

    reset = 1'b1;
    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) retBits[i] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {out_data, out_valid, busy, sel_err, scan_clk_out,
                                  scan_data_out, scan_select, scan_latch_en}, 0);
    checkOutput("reset_refresh_cnt", refresh_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    for (int v = 0; v < 3; v++) begin
      runRefresh($sformatf("vec%0d", v), vecs[v].sel, vecs[v].word, vecs[v].ws,
                 vecs[v].ret, vecs[v].expLat, vecs[v].expOut);
    end

    for (int r = 0; r < 6; r++) begin
      rs  = SEL_W'($urandom_range(0, ND - 1));
      rw  = NI'($urandom);
      rws = WS_W'($urandom_range(0, 3));
      rr  = NI'($urandom);
      runRefresh($sformatf("rand%0d", r), rs, rw, rws, rr, refLatency(int'(rs), int'(rws)), rr);
    end

    // Out-of-range select: refused with one error pulse and no chain activity.
    @(negedge clk);
    errBase = selErrCnt; riseBase = busyRiseCnt; clkBase = scanClkCnt;
    applyStimulus(3'd4, 8'h55, 8'd2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("selerr_pulses", selErrCnt - errBase, 1);
    checkOutput("selerr_busy_rises", busyRiseCnt - riseBase, 0);
    checkOutput("selerr_scan_clks", scanClkCnt - clkBase, 0);

    // Inputs change and enable drops mid-shift: the running refresh keeps its values.
    @(negedge clk);
    loadChain(8'hD2);
    bitBase = inBits.size(); latchBase = latchCnt; vBase = validCnt;
    applyStimulus(3'd1, 8'h96, 8'd1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    active_select = 3'd3;
    in_data       = 8'hFF;
    enable        = 1'b0;
    waitValid("midchg", vBase + 1, 2000);
    modelCnt++;
    repeat (3) @(negedge clk);
    checkRefresh("midchg", 3'd1, 8'h96, 8'hD2, refLatency(1, 1), bitBase, latchBase, vBase);
    repeat (100) @(negedge clk);
    checkOutput("midchg_no_more_valid", validCnt - vBase, 1);
    continuous = 1'b0;

    // Continuous mode: enable dropped during the third refresh gives exactly three.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelCnt = 0;
    checkOutput("cont_cnt_cleared", refresh_cnt, 0);
    loadChain(8'h5E);
    bitBase = inBits.size(); vBase = validCnt; fallBase = busyFallCnt;
    applyStimulus(3'd2, 8'h3C, 8'd1, 1'b1, 1'b1, 1'b0);
    waitValid("cont2", vBase + 2, 3000);
    enable = 1'b0;
    waitValid("cont3", vBase + 3, 2000);
    modelCnt += 3;
    repeat (5) @(negedge clk);
    checkOutput("cont_valid_pulses", validCnt - vBase, 3);
    checkOutput("cont_refresh_cnt", refresh_cnt, modelCnt);
    checkOutput("cont_busy_falls", busyFallCnt - fallBase, 1);
    checkOutput("cont_out_data", out_data, 8'h5E);
    n = validCyc.size();
    checkOutput("cont_first_latency", (n >= 3) ? validCyc[n-3] - busyRiseCyc : -1, refLatency(2, 1));
    checkOutput("cont_gap1", (n >= 3) ? validCyc[n-2] - validCyc[n-3] : -1, refLatency(2, 1));
    checkOutput("cont_gap2", (n >= 3) ? validCyc[n-1] - validCyc[n-2] : -1, refLatency(2, 1));
    checkOutput("cont_bit_count", inBits.size() - bitBase, 3 * 3 * NI);
    bad = 0;
    for (int j = 0; j < 3 * 3 * NI; j++) begin
      if (bitBase + j >= inBits.size() ||
          inBits[bitBase + j] !== (((j % (3 * NI)) < NI) ? 1'((8'h3C >> (NI - 1 - (j % (3 * NI))))) : 1'b0))
        bad++;
    end
    checkOutput("cont_bit_values", bad, 0);
    continuous = 1'b0;

    // Reset during the output shift abandons the refresh without a capture.
    @(negedge clk);
    loadChain(8'hC3);
    vBase = validCnt;
    applyStimulus(3'd0, 8'h11, 8'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(outPhase && retIdx >= 3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_reached_out_shift", outPhase, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_outputs", {out_data, out_valid, busy, sel_err, scan_clk_out,
                                scan_data_out, scan_select, scan_latch_en}, 0);
    checkOutput("rst_refresh_cnt", refresh_cnt, 0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("rst_no_valid", validCnt - vBase, 0);
    checkOutput("rst_stays_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
